// File: rtl/gray_modn_counter.sv
// gray_modn_counter: up/down modulo-P_MODULUS counter with registered binary and Gray outputs.
// Supports synchronous clear/load, wrap or saturate at the boundary, and terminal-count,
// wrap, saturate and sticky load-error status.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst_n     synchronous active-low reset, clears every register
//   clr       synchronous clear to 0 (also clears err)
//   load      load min(load_val, P_MODULUS-1); out-of-range value sets err
//   load_val  value to load
//   en        count enable, one step per cycle
//   up        direction, 1 = increment, 0 = decrement
//   cnt_cmb   value cnt_reg takes at the next edge
//   cnt_reg   registered binary count
//   gray_reg  registered Gray code of cnt_reg
//   tc        terminal count for the current direction (combinational)
//   wrap      one-cycle pulse after a boundary crossing in wrap mode
//   sat       high after an enabled step was blocked at the boundary in saturate mode
//   err       sticky out-of-range load flag
module gray_modn_counter #(
  parameter int unsigned P_NUM_BITS = 8,
  parameter int unsigned P_MODULUS  = 2 ** P_NUM_BITS,
  parameter bit          P_SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [P_NUM_BITS-1:0] load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [P_NUM_BITS-1:0] cnt_cmb,
  output logic [P_NUM_BITS-1:0] cnt_reg,
  output logic [P_NUM_BITS-1:0] gray_reg,
  output logic                  tc,
  output logic                  wrap,
  output logic                  sat,
  output logic                  err
);

  localparam int unsigned N = P_NUM_BITS;

  // Compared in N+1 bits so P_MODULUS = 2**N still has a representable maximum.
  localparam logic [N:0]   MaxVal = (N + 1)'(P_MODULUS - 1);
  localparam logic [N-1:0] MaxCnt = MaxVal[N-1:0];
  localparam logic [N-1:0] One    = N'(1);

  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;
  logic         sat_q, sat_d;
  logic         err_q, err_d;

  logic at_max, at_zero;

  assign at_max  = ({1'b0, cnt_q} == MaxVal);
  assign at_zero = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    err_d  = err_q;
    if (!rst_n) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (clr) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (load) begin
      if ({1'b0, load_val} > MaxVal) begin
        cnt_d = MaxCnt;
        err_d = 1'b1;
      end else begin
        cnt_d = load_val;
      end
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          if (P_SATURATE) begin
            sat_d = 1'b1;
          end else begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + One;
        end
      end else begin
        if (at_zero) begin
          if (P_SATURATE) begin
            sat_d = 1'b1;
          end else begin
            cnt_d  = MaxCnt;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - One;
        end
      end
    end
  end

  // Gray derived from the next value so gray_reg tracks cnt_reg with no extra lag.
  assign gray_d = cnt_d ^ (cnt_d >> 1);

  // Reset is folded into the next-state logic above, so the flops load unconditionally.
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    gray_q <= gray_d;
    wrap_q <= wrap_d;
    sat_q  <= sat_d;
    err_q  <= err_d;
  end

  assign cnt_cmb  = cnt_d;
  assign cnt_reg  = cnt_q;
  assign gray_reg = gray_q;
  assign tc       = up ? at_max : at_zero;
  assign wrap     = wrap_q;
  assign sat      = sat_q;
  assign err      = err_q;

endmodule

// File: tb/tb_gray_modn_counter.sv
// Bench for gray_modn_counter: three instances (M=10 wrap, M=10 saturate, M=16 wrap) share
// one stimulus stream and are checked against an integer reference model.
module tb_gray_modn_counter;

  localparam int NI = 3;
  localparam int unsigned MOD_T [NI] = '{10, 10, 16};
  localparam bit          SAT_T [NI] = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n, clr, load, en, up;
  logic [3:0] load_val;

  logic [3:0] cnt_cmb [NI];
  logic [3:0] cnt_reg [NI];
  logic [3:0] gray_reg [NI];
  logic       tc [NI];
  logic       wrap [NI];
  logic       sat [NI];
  logic       err [NI];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int unsigned m_cnt [NI];
  bit          m_wrap [NI];
  bit          m_sat [NI];
  bit          m_err [NI];
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  gray_modn_counter #(.P_NUM_BITS(4), .P_MODULUS(10), .P_SATURATE(1'b0)) u_wrap10 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
    .cnt_cmb(cnt_cmb[0]), .cnt_reg(cnt_reg[0]), .gray_reg(gray_reg[0]), .tc(tc[0]),
    .wrap(wrap[0]), .sat(sat[0]), .err(err[0])
  );

  gray_modn_counter #(.P_NUM_BITS(4), .P_MODULUS(10), .P_SATURATE(1'b1)) u_sat10 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
    .cnt_cmb(cnt_cmb[1]), .cnt_reg(cnt_reg[1]), .gray_reg(gray_reg[1]), .tc(tc[1]),
    .wrap(wrap[1]), .sat(sat[1]), .err(err[1])
  );

  gray_modn_counter #(.P_NUM_BITS(4), .P_MODULUS(16), .P_SATURATE(1'b0)) u_wrap16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
    .cnt_cmb(cnt_cmb[2]), .cnt_reg(cnt_reg[2]), .gray_reg(gray_reg[2]), .tc(tc[2]),
    .wrap(wrap[2]), .sat(sat[2]), .err(err[2])
  );

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, inst, obs, exp);
    end
  endtask

  // Next state of the model from the counting rules, using modular integer arithmetic.
  function automatic void model_next(input int i, output int unsigned nc, output bit nw,
                                     output bit ns, output bit ne);
    int unsigned c = m_cnt[i];
    int unsigned m = MOD_T[i];
    nc = c;
    nw = 1'b0;
    ns = 1'b0;
    ne = m_err[i];
    if (!rst_n || clr) begin
      nc = 0;
      ne = 1'b0;
    end else if (load) begin
      nc = (int'(load_val) >= int'(m)) ? m - 1 : int'(load_val);
      ne = ne | (int'(load_val) >= int'(m));
    end else if (en) begin
      if ((up && c == m - 1) || (!up && c == 0)) begin
        if (SAT_T[i]) ns = 1'b1;
        else begin
          nc = up ? 0 : m - 1;
          nw = 1'b1;
        end
      end else begin
        nc = up ? (c + 1) % m : (c + m - 1) % m;
      end
    end
  endfunction

  function automatic logic [3:0] to_gray(input int unsigned b);
    logic [3:0] v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // One clock: check combinational outputs, take the edge, then check registered outputs.
  task automatic tick();
    int unsigned nc [NI];
    bit nw [NI], ns [NI], ne [NI];
    logic [3:0] prev_gray;
    bit stepped;
    #1;
    for (int i = 0; i < NI; i++) begin
      model_next(i, nc[i], nw[i], ns[i], ne[i]);
      if (m_valid) begin
        chk("cnt_cmb", i, 32'(cnt_cmb[i]), nc[i]);
        chk("tc", i, 32'(tc[i]), 32'(up ? (m_cnt[i] == MOD_T[i] - 1) : (m_cnt[i] == 0)));
      end
    end
    prev_gray = gray_reg[2];
    stepped = rst_n && !clr && !load && en;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      m_cnt[i]  = nc[i];
      m_wrap[i] = nw[i];
      m_sat[i]  = ns[i];
      m_err[i]  = ne[i];
      chk("cnt_reg", i, 32'(cnt_reg[i]), m_cnt[i]);
      chk("gray_reg", i, 32'(gray_reg[i]), 32'(to_gray(m_cnt[i])));
      chk("wrap", i, 32'(wrap[i]), 32'(m_wrap[i]));
      chk("sat", i, 32'(sat[i]), 32'(m_sat[i]));
      chk("err", i, 32'(err[i]), 32'(m_err[i]));
    end
    // Power-of-two modulus: every enabled step, wrap included, flips exactly one Gray bit.
    if (m_valid && stepped) chk("gray_1bit", 2, 32'($countones(prev_gray ^ gray_reg[2])), 32'd1);
    m_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = '0;
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_sat[i] = 0; m_err[i] = 0;
    end
    tick();
    tick();
    up = 1'b0;
    tick();
    chk("tc_reset_down", 0, 32'(tc[0]), 32'd1);

    // Count up across the M=10 boundary.
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    repeat (12) tick();
    chk("cnt_after_12", 0, 32'(cnt_reg[0]), 32'd2);

    // Down wrap from 2.
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    repeat (4) tick();
    chk("down_wrap_end", 0, 32'(cnt_reg[0]), 32'd8);

    // Saturate at 9.
    load = 1'b1; load_val = 4'd8; en = 1'b0; up = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    repeat (4) tick();
    chk("sat_hold", 1, 32'(cnt_reg[1]), 32'd9);

    // Out-of-range load clamps and sets err, err survives counting, clr clears it.
    load = 1'b1; load_val = 4'd13; en = 1'b0;
    tick();
    chk("clamp", 0, 32'(cnt_reg[0]), 32'd9);
    load = 1'b0; en = 1'b1;
    repeat (3) tick();
    en = 1'b0; clr = 1'b1;
    tick();
    chk("clr_err", 0, 32'(err[0]), 32'd0);

    // clr beats load and en.
    clr = 1'b0; load = 1'b1; load_val = 4'd7;
    tick();
    clr = 1'b1; load = 1'b1; en = 1'b1;
    tick();
    chk("priority", 2, 32'(cnt_reg[2]), 32'd0);

    // 20 up steps: M=16 rolls 15 -> 0.
    clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    repeat (20) tick();

    // Randomized traffic.
    repeat (400) begin
      rst_n    = ($urandom_range(0, 39) != 0);
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 1) == 1);
      tick();
    end

    // Reset mid-count with en and load also high.
    rst_n = 1'b1; clr = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd5;
    tick();
    chk("pre_reset", 0, 32'(cnt_reg[0]), 32'd5);
    rst_n = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd12;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk("rst_cnt", i, 32'(cnt_reg[i]), 32'd0);
      chk("rst_gray", i, 32'(gray_reg[i]), 32'd0);
      chk("rst_err", i, 32'(err[i]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
